// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
//   SB_CNT_W    : per-register pending counter width
//   SB_IDX_W    : architectural register index width
//   SB_NUM_REGS : architectural registers tracked (x0 never tracked)
//   sb_cnt_t    : one pending counter value
//   sb_wr_t     : issue / writeback bus (valid + destination register)
package reg_scoreboard_pkg;

  localparam int SB_CNT_W    = 2;
  localparam int SB_IDX_W    = 5;
  localparam int SB_NUM_REGS = 32;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  typedef struct packed {
    logic                valid;
    logic [SB_IDX_W-1:0] rd;
  } sb_wr_t;

endpackage

// File: rtl/reg_scoreboard_sb_cnt.sv
// One saturating up/down pending-write counter for a single register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear, dominates inc/dec
//   inc      : one more write in flight
//   dec      : one write retired
//   cnt      : current registered count
//   sat      : count at its maximum value
//   zero     : count is zero
//   uflow    : retire requested with nothing in flight (count held at 0)
module reg_scoreboard_sb_cnt
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             zero,
  output logic             uflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt   = cnt_q;
  assign sat   = (cnt_q == '1);
  assign zero  = (cnt_q == '0);
  // Simultaneous inc+dec cancels, so it never counts as an underflow.
  assign uflow = dec && !inc && !clr && zero;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight long-latency writes per destination
// register and answers decode-stage hazard queries.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN -- when defined, a query
// hitting a register with exactly one write in flight whose writeback fires
// this cycle reports not pending (value comes from the forwarding path).
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous clear of all pending counts
//   iss_valid, iss_rd    : long-latency op issued writing iss_rd
//   iss_ready            : issue accepted (0 = counter for iss_rd full)
//   wb_valid, wb_rd      : tracked writeback completes for wb_rd
//   q_rs1_use, q_rs1     : decode rs1 query
//   q_rs2_use, q_rs2     : decode rs2 query
//   rs1_pending          : rs1 has a write in flight (combinational)
//   rs2_pending          : rs2 has a write in flight (combinational)
//   stall                : either source pending
//   busy                 : any register has a write in flight
//   err_uflow            : sticky, writeback seen with nothing in flight
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int IDX_W    = SB_IDX_W,
  parameter int CNT_W    = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [IDX_W-1:0] iss_rd,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic             q_rs1_use,
  input  logic [IDX_W-1:0] q_rs1,
  input  logic             q_rs2_use,
  input  logic [IDX_W-1:0] q_rs2,
  output logic             rs1_pending,
  output logic             rs2_pending,
  output logic             stall,
  output logic             busy,
  output logic             err_uflow
);

  sb_wr_t iss_bus;
  sb_wr_t wb_bus;

  assign iss_bus.valid = iss_valid;
  assign iss_bus.rd    = iss_rd;
  assign wb_bus.valid  = wb_valid;
  assign wb_bus.rd     = wb_rd;

  logic [CNT_W-1:0]    cnt_w [NUM_REGS];
  logic [NUM_REGS-1:0] sat_w;
  logic [NUM_REGS-1:0] zero_w;
  logic [NUM_REGS-1:0] uflow_w;
  logic                iss_fire;
  logic                wb_fire;
  logic                err_uflow_q;
  logic                err_uflow_d;

  // x0 is hardwired: never pending, never full, never underflows.
  assign cnt_w[0]   = '0;
  assign sat_w[0]   = 1'b0;
  assign zero_w[0]  = 1'b1;
  assign uflow_w[0] = 1'b0;

  // A writeback to the same rd in this cycle frees the slot the issue needs.
  assign iss_ready = !sat_w[iss_bus.rd] || (wb_bus.valid && (wb_bus.rd == iss_bus.rd));
  assign iss_fire  = iss_bus.valid && iss_ready && (iss_bus.rd != '0);
  assign wb_fire   = wb_bus.valid && (wb_bus.rd != '0);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic inc_w;
    logic dec_w;
    assign inc_w = iss_fire && (iss_bus.rd == IDX_W'(i));
    assign dec_w = wb_fire  && (wb_bus.rd  == IDX_W'(i));

    reg_scoreboard_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .inc   (inc_w),
      .dec   (dec_w),
      .cnt   (cnt_w[i]),
      .sat   (sat_w[i]),
      .zero  (zero_w[i]),
      .uflow (uflow_w[i])
    );
  end

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = q_rs1_use && (q_rs1 != '0) && (cnt_w[q_rs1] != '0);
  assign rs2_hit = q_rs2_use && (q_rs2 != '0) && (cnt_w[q_rs2] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last outstanding write retiring now: forwarding covers the read.
  logic rs1_byp;
  logic rs2_byp;
  assign rs1_byp = wb_fire && (wb_bus.rd == q_rs1) && (cnt_w[q_rs1] == CNT_W'(1));
  assign rs2_byp = wb_fire && (wb_bus.rd == q_rs2) && (cnt_w[q_rs2] == CNT_W'(1));
  assign rs1_pending = rs1_hit && !rs1_byp;
  assign rs2_pending = rs2_hit && !rs2_byp;
`else
  assign rs1_pending = rs1_hit;
  assign rs2_pending = rs2_hit;
`endif

  assign stall = rs1_pending || rs2_pending;
  assign busy  = ~&zero_w;

  // Sticky until reset; flush does not clear it.
  assign err_uflow_d = err_uflow_q || (|uflow_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_uflow_q <= 1'b0;
    end else begin
      err_uflow_q <= err_uflow_d;
    end
  end

  assign err_uflow = err_uflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. Stimulus pushes the expected output
// vector {stall, rs1_pending, rs2_pending, busy, iss_ready, err_uflow} for
// each cycle into a queue; a monitor pops and compares on the falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       iss_valid;
  logic [4:0] iss_rd;
  logic       iss_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       q_rs1_use;
  logic [4:0] q_rs1;
  logic       q_rs2_use;
  logic [4:0] q_rs2;
  logic       rs1_pending;
  logic       rs2_pending;
  logic       stall;
  logic       busy;
  logic       err_uflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .q_rs1_use   (q_rs1_use),
    .q_rs1       (q_rs1),
    .q_rs2_use   (q_rs2_use),
    .q_rs2       (q_rs2),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .stall       (stall),
    .busy        (busy),
    .err_uflow   (err_uflow)
  );

  // Monitor: compare everything queued for this cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] got;
    got = {stall, rs1_pending, rs2_pending, busy, iss_ready, err_uflow};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got {stall,p1,p2,busy,ready,err}=%b expected %b", e.name, got, e.exp);
      end
    end
  end

  // Start a new cycle: wait for the edge, then drive this cycle's inputs.
  task automatic drive(input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd,
                       input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2,
                       input logic fl);
    @(posedge clk);
    #1;
    iss_valid = iv;  iss_rd = ird;
    wb_valid  = wv;  wb_rd  = wrd;
    q_rs1_use = u1;  q_rs1  = r1;
    q_rs2_use = u2;  q_rs2  = r2;
    flush     = fl;
  endtask

  task automatic expect_out(input string name, input logic [5:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    iss_valid = 1'b0; iss_rd = '0;
    wb_valid  = 1'b0; wb_rd  = '0;
    q_rs1_use = 1'b0; q_rs1  = '0;
    q_rs2_use = 1'b0; q_rs2  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //    iss      wb       rs1      rs2      flush         {stall,p1,p2,busy,ready,err}
    drive(0, 0,    0, 0,    0, 0,    0, 0,    0); expect_out("reset_idle",     6'b000010);

    // Load-use on x5
    drive(1, 5,    0, 0,    1, 5,    0, 0,    0); expect_out("lu_same_cycle",  6'b000010);
    drive(0, 0,    0, 0,    1, 5,    0, 0,    0); expect_out("lu_stall_c1",    6'b110110);
    drive(0, 0,    0, 0,    1, 5,    0, 0,    0); expect_out("lu_stall_c2",    6'b110110);
    drive(0, 0,    1, 5,    1, 5,    0, 0,    0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_out("lu_wb_c3", 6'b000110);
`else
    expect_out("lu_wb_c3", 6'b110110);
`endif
    drive(0, 0,    0, 0,    1, 5,    0, 0,    0); expect_out("lu_release_c4",  6'b000010);

    // Saturation on x7 (max 3 in flight)
    drive(1, 7,    0, 0,    0, 0,    0, 0,    0); expect_out("sat_iss1",       6'b000010);
    drive(1, 7,    0, 0,    0, 0,    0, 0,    0); expect_out("sat_iss2",       6'b000110);
    drive(1, 7,    0, 0,    0, 0,    0, 0,    0); expect_out("sat_iss3",       6'b000110);
    drive(1, 7,    0, 0,    0, 0,    0, 0,    0); expect_out("sat_iss4_block", 6'b000100);
    drive(1, 7,    1, 7,    0, 0,    0, 0,    0); expect_out("sat_iss_wb",     6'b000110);
    drive(1, 7,    0, 0,    0, 0,    0, 0,    0); expect_out("sat_still_full", 6'b000100);
    drive(0, 0,    1, 7,    0, 0,    1, 7,    0); expect_out("sat_drain1",     6'b101110);
    drive(0, 0,    1, 7,    0, 0,    1, 7,    0); expect_out("sat_drain2",     6'b101110);
    drive(0, 0,    0, 0,    0, 0,    1, 7,    0); expect_out("sat_one_left",   6'b101110);
    drive(0, 0,    1, 7,    0, 0,    0, 0,    0); expect_out("sat_drain3",     6'b000110);
    drive(0, 0,    0, 0,    0, 0,    1, 7,    0); expect_out("sat_empty",      6'b000010);

    // x0 and use bits
    drive(1, 0,    0, 0,    0, 0,    0, 0,    0); expect_out("x0_issue",       6'b000010);
    drive(0, 0,    0, 0,    1, 0,    1, 0,    0); expect_out("x0_after",       6'b000010);
    drive(1, 9,    0, 0,    0, 0,    0, 0,    0); expect_out("use_iss9",       6'b000010);
    drive(0, 0,    0, 0,    0, 0,    0, 9,    0); expect_out("use_rs2_off",    6'b000110);
    drive(0, 0,    0, 0,    0, 0,    1, 9,    0); expect_out("use_rs2_on",     6'b101110);
    drive(0, 0,    1, 9,    0, 0,    0, 0,    0); expect_out("use_wb9",        6'b000110);

    // Same-cycle issue + writeback at count 0: no change, no underflow
    drive(1, 11,   1, 11,   0, 0,    0, 0,    0); expect_out("same_iss_wb",    6'b000010);
    drive(0, 0,    0, 0,    1, 11,   0, 0,    0); expect_out("same_after",     6'b000010);

    // Underflow
    drive(0, 0,    1, 0,    0, 0,    0, 0,    0); expect_out("wb_x0",          6'b000010);
    drive(0, 0,    0, 0,    0, 0,    0, 0,    0); expect_out("wb_x0_after",    6'b000010);
    drive(0, 0,    1, 4,    0, 0,    0, 0,    0); expect_out("uflow_wb4",      6'b000010);
    drive(0, 0,    0, 0,    1, 4,    0, 0,    0); expect_out("uflow_set",      6'b000011);

    // Flush priority
    drive(1, 3,    0, 0,    0, 0,    0, 0,    0); expect_out("fl_iss3",        6'b000011);
    drive(1, 6,    0, 0,    0, 0,    0, 0,    0); expect_out("fl_iss6",        6'b000111);
    drive(1, 3,    0, 0,    1, 3,    1, 6,    1); expect_out("fl_flush",       6'b111111);
    drive(0, 0,    0, 0,    1, 3,    1, 6,    0); expect_out("fl_after",       6'b000011);
    drive(0, 0,    1, 6,    0, 0,    0, 0,    0); expect_out("fl_stray_wb",    6'b000011);
    drive(0, 0,    0, 0,    0, 0,    0, 0,    0); expect_out("fl_err_kept",    6'b000011);

    // Asynchronous reset mid-operation
    drive(1, 8,    0, 0,    0, 0,    0, 0,    0); expect_out("rm_iss8a",       6'b000011);
    drive(1, 8,    0, 0,    0, 0,    0, 0,    0); expect_out("rm_iss8b",       6'b000111);
    drive(1, 8,    0, 0,    0, 0,    0, 0,    0); expect_out("rm_iss8c",       6'b000111);
    drive(1, 8,    0, 0,    1, 8,    0, 0,    0); expect_out("rm_full",        6'b110101);
    drive(1, 8,    0, 0,    1, 8,    0, 0,    0);
    rst = 1'b1;                                   expect_out("rm_async",       6'b000010);
    drive(0, 0,    0, 0,    1, 8,    0, 0,    0);
    rst = 1'b0;                                   expect_out("rm_released",    6'b000010);
    drive(1, 8,    0, 0,    0, 0,    0, 0,    0); expect_out("post_rst_iss",   6'b000010);
    drive(0, 0,    0, 0,    1, 8,    0, 0,    0); expect_out("post_rst_q",     6'b110110);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
